// File: rtl/sign_frame_counter_if.sv
// Sample-in / count-out handshake bundle for sign_frame_counter.
interface sign_frame_counter_if #(
    parameter int W     = 8,
    parameter int FRAME = 16
);
    localparam int CW = $clog2(FRAME + 1);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic [CW-1:0] live_count;

    // Upstream sample source plus downstream count sink.
    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_count, live_count
    );

    // The counter itself.
    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_count, live_count
    );
endinterface

// File: rtl/sign_frame_counter.sv
// Frame-based sign statistics counter: counts samples per FRAME that match
// a selectable sign criterion and hands each frame count downstream.
module sign_frame_counter #(
    parameter int W     = 8,
    parameter int FRAME = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sign_frame_counter_if.slave  bus
);
    localparam int CW = $clog2(FRAME + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state_q;
    logic          in_rdy_q;
    logic          out_vld_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_d;
    logic [CW-1:0] out_cnt_q;
    logic [1:0]    mode_q;
    logic [1:0]    mode_eff;
    logic          prev_s_q;
    logic          s;
    logic          z;
    logic          match;
    logic          acc;
    logic          last;

    // Classify the presented sample; the frame's first sample uses the live
    // mode input since the latch only captures it on that same edge.
    always_comb begin
        s        = bus.in_data[W-1];
        z        = (bus.in_data == '0);
        mode_eff = (idx_q == '0) ? bus.mode : mode_q;
        match    = 1'b0;
        unique case (mode_eff)
            2'b00:   match = s;
            2'b01:   match = z;
            2'b10:   match = !s && !z;
            default: match = (idx_q != '0) && (s != prev_s_q);
        endcase
        cnt_d = cnt_q + CW'(match);
        idx_d = idx_q + CW'(1);
        acc   = bus.in_valid && in_rdy_q;
        last  = (idx_q == CW'(FRAME - 1));
    end

    // Frame FSM with registered handshake outputs; a completed frame parks
    // in HOLD until the downstream takes the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            out_cnt_q <= '0;
            mode_q    <= 2'b00;
            prev_s_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    in_rdy_q <= 1'b1;
                    if (acc) begin
                        if (last) begin
                            out_cnt_q <= cnt_d;
                            cnt_q     <= '0;
                            idx_q     <= '0;
                            prev_s_q  <= 1'b0;
                            in_rdy_q  <= 1'b0;
                            out_vld_q <= 1'b1;
                            state_q   <= HOLD;
                        end else begin
                            cnt_q    <= cnt_d;
                            idx_q    <= idx_d;
                            prev_s_q <= s;
                            if (idx_q == '0) mode_q <= bus.mode;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        in_rdy_q  <= 1'b1;
                        out_vld_q <= 1'b0;
                        state_q   <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready   = in_rdy_q;
    assign bus.out_valid  = out_vld_q;
    assign bus.out_count  = out_cnt_q;
    assign bus.live_count = cnt_q;
endmodule

// File: tb/tb_sign_frame_counter.sv
// Self-checking bench for sign_frame_counter: directed frames plus random
// traffic against a frame-level reference model.
module tb_sign_frame_counter;
    localparam int W     = 8;
    localparam int FRAME = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sign_frame_counter_if #(.W(W), .FRAME(FRAME)) bus ();

    sign_frame_counter #(.W(W), .FRAME(FRAME)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: samples of the frame in progress, the mode it
    // started with, completed counts awaiting handoff, expected outputs.
    int frame_q[$];
    int frame_mode = 0;
    int pending[$];
    int exp_oc = 0;
    bit exp_rdy = 1'b0;
    bit primed = 1'b0;

    function automatic int frame_matches();
        int c = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            case (frame_mode)
                0: c += (frame_q[i] < 0) ? 1 : 0;
                1: c += (frame_q[i] == 0) ? 1 : 0;
                2: c += (frame_q[i] > 0) ? 1 : 0;
                default: if (i > 0 && ((frame_q[i] < 0) != (frame_q[i-1] < 0))) c++;
            endcase
        end
        return c;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the
    // model to what the coming rising edge should do.
    task automatic step(input bit v, input int d, input int m, input bit ordy,
                        input bit r, output bit acc);
        @(negedge clk);
        if (primed) begin
            chk("in_ready",   int'(bus.in_ready),   int'(exp_rdy));
            chk("out_valid",  int'(bus.out_valid),  (pending.size() != 0) ? 1 : 0);
            chk("out_count",  int'(bus.out_count),  exp_oc);
            chk("live_count", int'(bus.live_count), frame_matches());
        end
        bus.in_valid  = v;
        bus.in_data   = d[W-1:0];
        bus.mode      = m[1:0];
        bus.out_ready = ordy;
        rst           = r;
        acc           = 1'b0;
        if (r) begin
            frame_q.delete();
            pending.delete();
            exp_oc  = 0;
            exp_rdy = 1'b0;
            primed  = 1'b1;
        end else begin
            if (pending.size() != 0 && ordy) pending.delete();
            if (v && exp_rdy) begin
                acc = 1'b1;
                if (frame_q.size() == 0) frame_mode = m;
                frame_q.push_back(d);
                if (frame_q.size() == FRAME) begin
                    exp_oc = frame_matches();
                    pending.push_back(exp_oc);
                    frame_q.delete();
                end
            end
            exp_rdy = (pending.size() == 0);
        end
    endtask

    task automatic push(input int d, input int m);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 20 && !a; k++) step(1'b1, d, m, 1'b0, 1'b0, a);
        chk("push_accept", int'(a), 1);
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d, input int m);
        push(a, m); push(b, m); push(c, m); push(d, m);
    endtask

    // Observe the held count one cycle after the last accept, then take it.
    task automatic take(input string tag, input int exp_c);
        bit a;
        step(1'b0, 0, 0, 1'b0, 1'b0, a);
        chk(tag, int'(bus.out_count), exp_c);
        chk({tag, "_vld"}, int'(bus.out_valid), 1);
        step(1'b0, 0, 0, 1'b1, 1'b0, a);
    endtask

    initial begin
        bit a;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;

        step(1'b0, 0, 0, 1'b0, 1'b1, a);
        step(1'b0, 0, 0, 1'b0, 1'b1, a);
        step(1'b0, 0, 0, 1'b0, 1'b0, a);
        chk("reset_in_ready", int'(bus.in_ready), 0);
        chk("reset_out_valid", int'(bus.out_valid), 0);

        // Negative count, then backpressure with upstream pushing.
        frame4(-1, 5, -128, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 9, 0, 1'b0, 1'b0, a);
            chk("bp_count", int'(bus.out_count), 2);
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        step(1'b0, 0, 0, 1'b1, 1'b0, a);

        frame4(0, 0, 3, 0, 1);          take("zero", 3);
        frame4(127, 127, 1, 127, 2);    take("pos_full", 4);
        frame4(5, -3, -4, 2, 3);        take("chg_a", 2);
        frame4(-1, -1, 7, 7, 3);        take("chg_b", 1);

        // Mode change mid-frame only applies from the next frame.
        push(-2, 0); push(-2, 0); push(4, 2); push(4, 2); take("latch_a", 2);
        push(1, 2); push(0, 0); push(-1, 0); push(5, 0);  take("latch_b", 2);

        // Idle gaps between samples.
        push(-5, 0); step(1'b0, -9, 0, 1'b0, 1'b0, a);
        push(3, 0);  step(1'b0, -9, 0, 1'b0, 1'b0, a);
        push(-1, 0); step(1'b0, -9, 0, 1'b0, 1'b0, a);
        push(-7, 0); take("gaps", 3);

        // Reset mid-frame discards the partial frame.
        push(-1, 0); push(-2, 0);
        step(1'b0, 0, 0, 1'b0, 1'b1, a);
        step(1'b0, 0, 0, 1'b0, 1'b0, a);
        chk("rst_live", int'(bus.live_count), 0);
        chk("rst_out_count", int'(bus.out_count), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        frame4(-1, -1, -1, 1, 0);       take("after_rst", 3);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            int d;
            int sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: d = 0;
                1: d = 127;
                2: d = -128;
                3: d = -1;
                default: d = int'($urandom_range(0, 255)) - 128;
            endcase
            step($urandom_range(0, 3) != 0, d, int'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 79) == 0, a);
        end
        step(1'b0, 0, 0, 1'b0, 1'b0, a);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
